// File: rtl/v6502_pkg.sv
// Shared fetch-path definitions for the v6502 core: fetch FSM states and
// default queue geometry / reset vector.
package v6502_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned FQ_DEPTH    = 16;
    localparam int unsigned FQ_AW       = 4;
    localparam logic [15:0] FQ_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_byte_ring.sv
// Circular instruction-byte storage: one write port, three read ports at
// consecutive addresses starting from the read pointer (wrapping mod DEPTH).
module fetch_byte_ring #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata0_o,
    output logic [7:0]    rdata1_o,
    output logic [7:0]    rdata2_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        raddr1 = raddr_i + AW'(1);
        raddr2 = raddr_i + AW'(2);
    end

    assign rdata0_o = mem_q[raddr_i];
    assign rdata1_o = mem_q[raddr1];
    assign rdata2_o = mem_q[raddr2];

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction prefetch sequencer: single-outstanding byte reads into a
// circular queue, 3-byte decoder window, redirect flush with stale-read drop.
module fetch_queue_ctrl
    import v6502_pkg::*;
#(
    parameter int unsigned DEPTH    = FQ_DEPTH,
    parameter int unsigned AW       = FQ_AW,
    parameter logic [15:0] RESET_PC = FQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        bus_hold,
    input  logic        dec_take,
    input  logic [1:0]  dec_len,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [7:0]  q_byte0,
    output logic [7:0]  q_byte1,
    output logic [7:0]  q_byte2,
    output logic [AW:0] q_avail,
    output logic [15:0] head_pc,
    output logic        dec_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   fetch_addr_q, fetch_addr_d;
    logic [15:0]   head_pc_q, head_pc_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          dec_err_q, dec_err_d;

    logic          in_flight;
    logic          wr_en;
    logic          take_ok;
    logic          pop;
    logic [AW:0]   len_w;
    logic [7:0]    rd0, rd1, rd2;

    fetch_byte_ring #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk_i    (clk),
        .we_i     (wr_en),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (mem_rdata),
        .raddr_i  (rd_ptr_q),
        .rdata0_o (rd0),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    always_comb begin
        in_flight = (state_q != ST_IDLE);
        len_w     = (AW+1)'(dec_len);
        take_ok   = dec_take && (dec_len != 2'd0) && (len_w <= count_q);
        // Redirect wins over both the ack write and the decoder pop.
        wr_en     = (state_q == ST_REQ) && mem_ack && !redirect;
        pop       = take_ok && !redirect;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fetch_addr_d = fetch_addr_q;
        head_pc_d    = head_pc_q;
        dec_err_d    = dec_err_q;
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;

        if (redirect) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = redirect_pc;
            head_pc_d    = redirect_pc;
            dec_err_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d     = wr_ptr_q + AW'(1);
                fetch_addr_d = fetch_addr_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(dec_len);
                head_pc_d = head_pc_q + 16'(dec_len);
            end
            count_d = count_q + (AW+1)'(wr_en) - (pop ? len_w : '0);
            if (dec_take && !take_ok) begin
                dec_err_d = 1'b1;
            end
        end

        // Bus is free after this edge when idle or on the ack cycle; the address
        // tracks the fetch PC whenever nothing is outstanding.
        if (redirect && in_flight && !mem_ack) begin
            state_d = ST_DROP;
        end else if (!in_flight || mem_ack) begin
            mem_addr_d = fetch_addr_d;
            if (!bus_hold && (count_d < DEPTH_C)) begin
                state_d = ST_REQ;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fetch_addr_q <= RESET_PC;
            head_pc_q    <= RESET_PC;
            mem_addr_q   <= RESET_PC;
            dec_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            mem_addr_q   <= mem_addr_d;
            dec_err_q    <= dec_err_d;
        end
    end

    assign mem_req  = (state_q != ST_IDLE);
    assign mem_addr = mem_addr_q;
    assign q_avail  = count_q;
    assign head_pc  = head_pc_q;
    assign dec_err  = dec_err_q;
    assign q_byte0  = (count_q > (AW+1)'(0)) ? rd0 : '0;
    assign q_byte1  = (count_q > (AW+1)'(1)) ? rd1 : '0;
    assign q_byte2  = (count_q > (AW+1)'(2)) ? rd2 : '0;

endmodule
